// File: rtl/note_recorder.sv
// note_recorder: captures {t3,t2,t1,t0} into note memory at SLOW_CLK_SPEED notes/s.
// Define NOTE_REC_LOOP_EN to wrap at limit_addr and keep recording until rec_stop.
module note_recorder #(
  parameter logic [31:0] MAIN_CLK_SPEED = 32'd50000000,
  parameter logic [31:0] SLOW_CLK_SPEED = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rec_start,
  input  logic        rec_stop,
  input  logic [9:0]  base_addr,
  input  logic [9:0]  limit_addr,
  input  logic [3:0]  t0,
  input  logic [3:0]  t1,
  input  logic [3:0]  t2,
  input  logic [3:0]  t3,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic [9:0]  start_addr,
  output logic [9:0]  end_addr,
  output logic        recording,
  output logic        done,
  output logic        full
);
  localparam logic [31:0] DIV = MAIN_CLK_SPEED / SLOW_CLK_SPEED;
  typedef enum logic [1:0] {IDLE, RECORD, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] div_q, div_d;
  logic [9:0] wp_q, wp_d, limit_q, limit_d, start_q, start_d, end_q, end_d, mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic mem_we_q, mem_we_d, recording_q, recording_d, done_q, done_d, full_q, full_d;
  logic tick;
  logic [9:0] wp_inc;
  assign tick = (state_q == RECORD) && (div_q == DIV - 32'd1);
  assign wp_inc = wp_q + 10'd1;
  always_comb begin
    state_d = state_q;
    div_d = div_q;
    wp_d = wp_q;
    limit_d = limit_q;
    start_d = start_q;
    end_d = end_q;
    full_d = full_q;
    mem_we_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_q == IDLE) begin
      if (rec_start) begin
        start_d = base_addr;
        wp_d = base_addr;
        limit_d = limit_addr;
        full_d = 1'b0;
        div_d = 32'd0;
        state_d = (base_addr < limit_addr) ? RECORD : DONE;
        end_d = (base_addr < limit_addr) ? end_q : base_addr;
      end
    end else if (state_q == RECORD) begin
      div_d = tick ? 32'd0 : div_q + 32'd1;
      if (tick) begin
        mem_we_d = 1'b1;
        mem_addr_d = wp_q;
        mem_wdata_d = {t3, t2, t1, t0};
        wp_d = wp_inc;
        if (wp_inc == limit_q) begin
          full_d = 1'b1;
`ifdef NOTE_REC_LOOP_EN
          wp_d = start_q;
`else
          state_d = DONE;
          end_d = limit_q;
`endif
        end
      end
      // full implies the range is saturated, so the stop point is the limit
      if (rec_stop) begin
        state_d = DONE;
        end_d = full_d ? limit_q : wp_d;
      end
    end else begin
      state_d = IDLE;
    end
    done_d = (state_d == DONE);
    recording_d = (state_d == RECORD);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q <= '0;
      wp_q <= '0;
      limit_q <= '0;
      start_q <= '0;
      end_q <= '0;
      full_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      recording_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      wp_q <= wp_d;
      limit_q <= limit_d;
      start_q <= start_d;
      end_q <= end_d;
      full_q <= full_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      recording_q <= recording_d;
      done_q <= done_d;
    end
  end
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign start_addr = start_q;
  assign end_addr = end_q;
  assign recording = recording_q;
  assign done = done_q;
  assign full = full_q;
endmodule

// File: doc/note_recorder.md
NOTE_RECORDER -- requirements
Module: note_recorder

Interface
REQ-001 Parameter MAIN_CLK_SPEED, default 32'd50000000, system clock frequency in Hz.
REQ-002 Parameter SLOW_CLK_SPEED, default 32'd4, note capture rate in notes per second; DIV = MAIN_CLK_SPEED/SLOW_CLK_SPEED, always >= 2.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rec_start  input  1  one-cycle request to begin recording.
REQ-006 rec_stop  input  1  one-cycle request to end recording.
REQ-007 base_addr  input  10  first note-memory address to write; sampled on accepted rec_start.
REQ-008 limit_addr  input  10  exclusive upper address bound; sampled on accepted rec_start.
REQ-009 t0, t1, t2, t3  input  4 each  live per-voice tone codes to capture.
REQ-010 mem_we  output  1  note-memory write strobe.
REQ-011 mem_addr  output  10  note-memory write address.
REQ-012 mem_wdata  output  16  note word {t3,t2,t1,t0}.
REQ-013 start_addr, end_addr  output  10 each  recorded range for the player; end_addr exclusive.
REQ-014 recording  output  1  high while in RECORD.
REQ-015 done  output  1  one-cycle pulse when a recording completes.
REQ-016 full  output  1  sticky; set when recording ended by reaching limit_addr.

Function
REQ-017 The block SHALL implement states IDLE, RECORD, DONE; reset state IDLE.
REQ-018 In IDLE, rec_start with base_addr < limit_addr SHALL move to RECORD next cycle, load write pointer wp <= base_addr, start_addr <= base_addr, clear full and the divider.
REQ-019 In IDLE, rec_start with base_addr >= limit_addr SHALL go to DONE with start_addr = end_addr = base_addr and no write.
REQ-020 In RECORD a divider SHALL count 0..DIV-1 and raise an internal tick on count DIV-1; the first tick occurs DIV cycles after entering RECORD.
REQ-021 On each tick the block SHALL, in the following cycle, assert mem_we for exactly one cycle with mem_addr = wp and mem_wdata = {t3,t2,t1,t0} sampled on the tick cycle, then wp <= wp + 1.
REQ-022 mem_we SHALL be low in all cycles other than those in REQ-021.
REQ-023 rec_stop in RECORD SHALL move to DONE with end_addr = wp after any write in progress; if rec_stop and tick coincide, that note SHALL be written and counted in end_addr.
REQ-024 When a write makes wp equal limit_addr, the block SHALL go to DONE, set full, end_addr = limit_addr (unless REQ-030 applies).
REQ-025 DONE SHALL last one cycle with done = 1, then return to IDLE; start_addr, end_addr, full hold until the next accepted rec_start.
REQ-026 rec_start in RECORD or DONE SHALL be ignored; rec_stop outside RECORD SHALL be ignored.
REQ-027 Address arithmetic SHALL be 10-bit unsigned; wp never exceeds limit_addr.

Reset
REQ-028 Reset SHALL force IDLE and clear divider, wp, mem_we, mem_addr, mem_wdata, start_addr, end_addr, recording, done, full to 0, overriding any input in the same cycle, including mid-recording.

Configuration
REQ-029 Macro NOTE_REC_LOOP_EN SHALL select loop recording.
REQ-030 With NOTE_REC_LOOP_EN defined, wp reaching limit_addr SHALL wrap to base_addr, set full, and continue RECORD until rec_stop; end_addr on stop = limit_addr if full else wp.
REQ-031 Without NOTE_REC_LOOP_EN, REQ-024 applies and no wrap logic SHALL exist.

Verification
REQ-032 MAIN=8, SLOW=4, base 0, limit 16, rec_start, tones 1,2,3,4 -> mem_we every 2 cycles, addr 0,1,2..., wdata 16'h4321.
REQ-033 Same setup, rec_stop after 5 writes -> done pulse, start_addr 0, end_addr 5, full 0.
REQ-034 No stop, base 0 limit 16 -> 16 writes (addr 0..15), done, full 1, end_addr 16; with NOTE_REC_LOOP_EN, 17th write to addr 0, recording stays 1.
REQ-035 rec_stop in same cycle as tick -> that write occurs, end_addr counts it.
REQ-036 base 20, limit 20 -> no mem_we, done pulse, start_addr = end_addr = 20.
REQ-037 reset asserted mid-recording -> next cycle all outputs 0, state IDLE, no further writes.
